// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Brief    : Shared constants and helpers for the ALU share arbiter.
// Revision : 1.0
// ============================================================================
package alu_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int c_default_n        = 16;
    localparam int c_default_max_hold = 16;

    // Widest request vector onehot_to_idx can encode.
    localparam int c_idx_vec_w = 256;

    function automatic logic [31:0] onehot_to_idx(input logic [c_idx_vec_w-1:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < c_idx_vec_w; i++) begin
            if (oh[i]) begin
                idx = idx | 32'(i);
            end
        end
        return idx;
    endfunction

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Brief    : Requester/ALU-steering bus between requesters and the arbiter.
// Revision : 1.0
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int N = 16
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           start;
    logic           timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  start,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output start,
        output timeout
    );

endinterface : alu_share_arbiter_if
`default_nettype wire

// File: rtl/alu_share_arbiter_msb_pick.sv
`default_nettype none
// ============================================================================
// Module   : msb_pick
// Brief    : Combinational one-hot of the most significant set bit.
// Revision : 1.0
// ============================================================================
module msb_pick #(
    parameter int N = 16
) (
    input  wire logic [N-1:0] i_vec,
    output logic      [N-1:0] o_onehot
);

    logic w_found;

    always_comb begin
        o_onehot = '0;
        w_found  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i] && !w_found) begin
                o_onehot[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

endmodule : msb_pick
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin, MSB-first arbiter time-sharing one multi-cycle ALU.
// Revision : 1.0
// ============================================================================
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N        = c_default_n,
    parameter int MAX_HOLD = c_default_max_hold
) (
    input wire logic           clk,
    input wire logic           rst_n,
    alu_share_arbiter_if.slave bus
);

    localparam int IDW     = $clog2(N);
    localparam int c_cnt_w = $clog2(MAX_HOLD);

    logic [0:0]         r_state,     w_state_nxt;
    logic [c_cnt_w-1:0] r_hold_cnt,  w_hold_cnt_nxt;
    logic [N-1:0]       r_prio_mask, w_prio_mask_nxt;
    logic [N-1:0]       r_gnt,       w_gnt_nxt;
    logic [IDW-1:0]     r_gnt_id,    w_gnt_id_nxt;
    logic               r_start,     w_start_nxt;
    logic               r_timeout,   w_timeout_nxt;

    logic [N-1:0]       w_masked;
    logic [N-1:0]       w_pick_masked;
    logic [N-1:0]       w_pick_full;
    logic [N-1:0]       w_win;
    logic [IDW-1:0]     w_win_idx;

    assign w_masked = bus.req & r_prio_mask;

    msb_pick #(.N(N)) u_pick_masked (
        .i_vec    (w_masked),
        .o_onehot (w_pick_masked)
    );

    msb_pick #(.N(N)) u_pick_full (
        .i_vec    (bus.req),
        .o_onehot (w_pick_full)
    );

    // An empty masked set wraps the rotation back to the full request vector.
    assign w_win     = (|w_masked) ? w_pick_masked : w_pick_full;
    assign w_win_idx = IDW'(onehot_to_idx(c_idx_vec_w'(w_win)));

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_prio_mask_nxt = r_prio_mask;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_start_nxt     = 1'b0;
        w_timeout_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt      = '0;
                w_hold_cnt_nxt = '0;
                if (|bus.req) begin
                    w_gnt_nxt       = w_win;
                    w_gnt_id_nxt    = w_win_idx;
                    w_start_nxt     = 1'b1;
                    w_state_nxt     = ST_BUSY;
                    // One-hot minus one sets exactly the bits below the winner.
                    w_prio_mask_nxt = w_win - N'(1);
                end
            end
            ST_BUSY: begin
                w_hold_cnt_nxt = r_hold_cnt + c_cnt_w'(1);
                if (bus.done) begin
                    w_gnt_nxt      = '0;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = ST_IDLE;
                end else if (r_hold_cnt == c_cnt_w'(MAX_HOLD - 1)) begin
                    w_gnt_nxt      = '0;
                    w_hold_cnt_nxt = '0;
                    w_timeout_nxt  = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: begin
                w_gnt_nxt      = '0;
                w_hold_cnt_nxt = '0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= '0;
            r_prio_mask <= '1;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_start     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_prio_mask <= w_prio_mask_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_start     <= w_start_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = |r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.start     = r_start;
    assign bus.timeout   = r_timeout;

endmodule : alu_share_arbiter
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed per-cycle vectors for alu_share_arbiter, N=4, MAX_HOLD=8.
// Revision : 1.0
// ============================================================================
module tb_alu_share_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_share_arbiter_if #(.N(4)) bus ();

    alu_share_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       gv;
        logic [1:0] id;
        logic       start;
        logic       to;
    } vec_t;

    localparam int c_nvec = 30;
    vec_t vecs [c_nvec];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic step(input string tag, input logic r, input logic [3:0] q, input logic d,
                        input logic [3:0] eg, input logic ev, input logic [1:0] eid,
                        input logic es, input logic et);
        @(negedge clk);
        rst_n    = r;
        bus.req  = q;
        bus.done = d;
        @(posedge clk);
        #1;
        chk({tag, ".gnt"},       int'(bus.gnt),       int'(eg));
        chk({tag, ".gnt_valid"}, int'(bus.gnt_valid), int'(ev));
        chk({tag, ".gnt_id"},    int'(bus.gnt_id),    int'(eid));
        chk({tag, ".start"},     int'(bus.start),     int'(es));
        chk({tag, ".timeout"},   int'(bus.timeout),   int'(et));
        chk({tag, ".onehot0"},   int'($onehot0(bus.gnt)), 1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;

        //                rst   req      done  gnt      gv    id     start to
        // reset held with all requests active
        vecs[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        // single grant; grantee dropping req keeps the grant
        vecs[2]  = '{1'b1, 4'b0110, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 4'b0110, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
        // round robin from a fresh mask
        vecs[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
        // reset mid-op restores the all-ones mask
        vecs[22] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
        vecs[24] = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[26] = '{1'b1, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[27] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
        // done in IDLE is ignored
        vecs[28] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
        vecs[29] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};

        for (int i = 0; i < c_nvec; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].req, vecs[i].done,
                 vecs[i].gnt, vecs[i].gv, vecs[i].id, vecs[i].start, vecs[i].to);
        end

        // Timeout: eight held cycles, forced release, regrant after one idle cycle.
        step("to_rst", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("to_hold%0d", i), 1'b1, 4'b0001, 1'b0,
                 4'b0001, 1'b1, 2'd0, (i == 0), 1'b0);
        end
        step("to_release", 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
        step("to_regrant", 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0);

        // Done on the last allowed cycle wins over timeout.
        for (int i = 1; i < 8; i++) begin
            step($sformatf("dt_hold%0d", i), 1'b1, 4'b0001, 1'b0,
                 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        step("dt_release", 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("dt_idle",    1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_share_arbiter
`default_nettype wire
